opl3_host_wr_if: RTL and testbench

Host-side producer of the `opl3_reg_wr` register-write bus. Decodes the four OPL3 I/O ports (bank-0 address, data, bank-1 address, data), latches the register index and bank, and queues data writes in a FIFO. Writes are replayed as single-cycle `opl3_reg_wr` strobes at a programmable minimum spacing. It sits between the ISA/port bridge and every `opl3_reg_wr` consumer: operator/channel register files, the kon-bit LED indicators, and so on.

---
 rtl/opl3_host_wr_if.sv | 210 +++++++++++++++++++++
 tb/tb_opl3_host_wr_if.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_host_wr_if.sv
// ---------------------------------------------------------------------------
// opl3_host_wr_if
//
// Host-side producer of the opl3_reg_wr register-write bus.
//
// The block decodes the four OPL3 I/O ports:
//   - Address-port writes latch the register index and the bank.
//   - Data-port writes queue {bank, index, data}.
// Queued writes are replayed as single-cycle opl3_reg_wr strobes. Successive
// strobes are separated by at least WR_SPACING clocks.
//
// Configuration macro: OPL3_HOST_FIFO_EN
//   defined   : FIFO_DEPTH-entry FIFO of pending data writes
//   undefined : single-entry holding register (FIFO_DEPTH ignored)
//
// Parameters:
//   FIFO_DEPTH  queued data writes (power of two, >= 2)
//   WR_SPACING  minimum clocks between valid pulses (>= 1)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   host_wr      one-cycle port write strobe
//   host_addr    port select (bit0: 0 = address, 1 = data; bit1: bank)
//   host_data    port write data
//   host_ready   a data-port write this cycle will be accepted
//   ovf          sticky flag: a data write was dropped
//   opl3_reg_wr  {valid, bank_num, address, data} to register consumers
// ---------------------------------------------------------------------------
package opl3_host_wr_pkg;
    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;
endpackage

module opl3_host_wr_if
    import opl3_host_wr_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int WR_SPACING = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         host_wr,
    input  logic [1:0]   host_addr,
    input  logic [7:0]   host_data,
    output logic         host_ready,
    output logic         ovf,
    output opl3_reg_wr_t opl3_reg_wr
);

    localparam int GAP_W = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(WR_SPACING - 1);

    // Queued entry layout: {bank, index, data}
    localparam int ENTRY_W = 17;

    logic               data_wr;
    logic               addr_wr;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_entry;

    logic [7:0]         idx_q,  idx_d;
    logic               bank_q, bank_d;
    logic               ovf_q,  ovf_d;
    logic [GAP_W-1:0]   gap_q,  gap_d;
    opl3_reg_wr_t       out_q,  out_d;

    assign data_wr    = host_wr &  host_addr[0];
    assign addr_wr    = host_wr & ~host_addr[0];

    // Occupancy is the registered value, so a pop in the same cycle never
    // lets a full store take the write.
    assign push       = data_wr & ~full;
    assign pop        = (gap_q == '0) & ~empty;

    // The entry uses the index/bank latched before this cycle's write.
    assign push_entry = {bank_q, idx_q, host_data};

`ifdef OPL3_HOST_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [ENTRY_W-1:0] hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;

    assign full  = hold_full_q;
    assign empty = ~hold_full_q;
    assign head  = hold_q;

    // A push only happens while empty and a pop only while full, so the
    // two never coincide.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (push) begin
            hold_d      = push_entry;
            hold_full_d = 1'b1;
        end else if (pop) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    // The pacing counter reloads on each pop. It counts down to zero while
    // idle, so the first write after a quiet period goes out immediately.
    // Output fields other than valid hold their last values between strobes.
    always_comb begin
        idx_d  = idx_q;
        bank_d = bank_q;
        ovf_d  = ovf_q | (data_wr & full);
        gap_d  = gap_q;
        out_d  = out_q;
        out_d.valid = 1'b0;
        if (addr_wr) begin
            idx_d  = host_data;
            bank_d = host_addr[1];
        end
        if (pop) begin
            out_d = {1'b1, head};
            gap_d = GAP_RELOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            bank_q <= 1'b0;
            ovf_q  <= 1'b0;
            gap_q  <= '0;
            out_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            bank_q <= bank_d;
            ovf_q  <= ovf_d;
            gap_q  <= gap_d;
            out_q  <= out_d;
        end
    end

    assign host_ready  = ~full;
    assign ovf         = ovf_q;
    assign opl3_reg_wr = out_q;

endmodule

// File: tb/tb_opl3_host_wr_if.sv
// Self-checking bench for opl3_host_wr_if (default parameters).
// Expected strobes are queued by the stimulus and consumed by the monitor.
module tb_opl3_host_wr_if;
    import opl3_host_wr_pkg::*;

    localparam int SPACING = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         host_wr   = 1'b0;
    logic [1:0]   host_addr = 2'd0;
    logic [7:0]   host_data = 8'd0;
    logic         host_ready;
    logic         ovf;
    opl3_reg_wr_t opl3_reg_wr;

    int           cycle  = 0;
    int           checks = 0;
    int           errors = 0;
    logic [16:0]  expq[$];
    int           vtimes[$];

    opl3_host_wr_if #(
        .FIFO_DEPTH (16),
        .WR_SPACING (SPACING)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .ovf         (ovf),
        .opl3_reg_wr (opl3_reg_wr)
    );

    always #5 clk = ~clk;

    // Counts rising edges seen so far.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (opl3_reg_wr.valid === 1'b1) begin
            vtimes.push_back(cycle);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got 0x%0h expected no strobe",
                         opl3_reg_wr[16:0]);
            end else begin
                checkOutput("strobe", {15'd0, opl3_reg_wr[16:0]}, {15'd0, expq.pop_front()});
            end
        end
    end

    // Issue one port write. For data writes, host_ready is checked against
    // the expected acceptance and the accepted entry is queued.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d,
                                 input logic exp_accept, input logic [16:0] exp_entry,
                                 output int edge_cycle);
        @(negedge clk);
        host_wr   = 1'b1;
        host_addr = a;
        host_data = d;
        #1;
        if (a[0]) checkOutput("host_ready_at_write", {31'd0, host_ready}, {31'd0, exp_accept});
        @(posedge clk);
        if (a[0] && exp_accept) expq.push_back(exp_entry);
        #1;
        edge_cycle = cycle;
        host_wr    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Wait (bounded) until every expected strobe has appeared, then let the
    // pacing counter run out.
    task automatic waitDrain();
        int budget = 0;
        while (expq.size() != 0 && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", expq.size());
            expq.delete();
        end
        idle(SPACING + 8);
    endtask

    task automatic checkPulses(input string name, input int n0, input int cnt,
                               input int first, input int spacing);
        checkOutput({name, "_count"}, vtimes.size() - n0, cnt);
        for (int k = 0; k < cnt; k++) begin
            if (n0 + k < vtimes.size())
                checkOutput({name, "_time"}, vtimes[n0 + k], first + k * spacing);
        end
    endtask

    // Which write of a back-to-back burst (started with gap==0 and an empty
    // store) is accepted.
    function automatic logic burstAccept(input int i);
`ifdef OPL3_HOST_FIFO_EN
        return (i <= 16);
`else
        return (i == 0 || i == 2);
`endif
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e, e0, n0;

        // Reset and idle.
        idle(3);
        #1;
        checkOutput("reset_out", {14'd0, opl3_reg_wr}, 32'h0);
        checkOutput("reset_ready", {31'd0, host_ready}, 32'd1);
        checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = vtimes.size();
        idle(100);
        #1;
        checkOutput("idle_pulses", vtimes.size() - n0, 0);
        checkOutput("idle_out", {14'd0, opl3_reg_wr}, 32'h0);

        // Bank 0 write with single-cycle latency.
        applyStimulus(2'd0, 8'hB0, 1'b1, 17'h0, e);
        n0 = vtimes.size();
        applyStimulus(2'd1, 8'h25, 1'b1, {1'b0, 8'hB0, 8'h25}, e);
        idle(3);
        checkPulses("bank0_latency", n0, 1, e + 1, 0);
        #1;
        checkOutput("fields_hold", {14'd0, opl3_reg_wr}, {14'd0, 1'b0, 1'b0, 8'hB0, 8'h25});
        waitDrain();

        // Bank 1 write, then a reused index.
        applyStimulus(2'd2, 8'h05, 1'b1, 17'h0, e);
        n0 = vtimes.size();
        applyStimulus(2'd3, 8'h01, 1'b1, {1'b1, 8'h05, 8'h01}, e);
        idle(3);
        checkPulses("bank1_latency", n0, 1, e + 1, 0);
        waitDrain();
        n0 = vtimes.size();
        applyStimulus(2'd3, 8'h02, 1'b1, {1'b1, 8'h05, 8'h02}, e);
        idle(3);
        checkPulses("reuse_idx", n0, 1, e + 1, 0);
        waitDrain();

        // Five writes paced SPACING clocks apart.
        applyStimulus(2'd0, 8'h40, 1'b1, 17'h0, e);
        n0 = vtimes.size();
        e0 = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd1, 8'h10 + 8'(i), 1'b1, {1'b0, 8'h40, 8'h10 + 8'(i)}, e);
            if (i == 0) e0 = e;
`ifndef OPL3_HOST_FIFO_EN
            if (i < 4) idle(SPACING - 1);
`endif
        end
        waitDrain();
        checkPulses("spacing", n0, 5, e0 + 1, SPACING);
        checkOutput("ovf_before_fill", {31'd0, ovf}, 32'd0);

        // Overfill: excess writes are dropped and ovf sticks.
        applyStimulus(2'd2, 8'h20, 1'b1, 17'h0, e);
        n0 = vtimes.size();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2'd3, 8'h60 + 8'(i), burstAccept(i), {1'b1, 8'h20, 8'h60 + 8'(i)}, e);
        end
        checkOutput("ready_low_when_full", {31'd0, host_ready}, 32'd0);
        checkOutput("ovf_after_fill", {31'd0, ovf}, 32'd1);
        waitDrain();
`ifdef OPL3_HOST_FIFO_EN
        checkOutput("fill_pulses", vtimes.size() - n0, 17);
`else
        checkOutput("fill_pulses", vtimes.size() - n0, 2);
`endif
        #1;
        checkOutput("ready_after_drain", {31'd0, host_ready}, 32'd1);
        checkOutput("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Reset with writes queued.
        applyStimulus(2'd0, 8'h33, 1'b1, 17'h0, e);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'd1, 8'h80 + 8'(i), burstAccept(i), {1'b0, 8'h33, 8'h80 + 8'(i)}, e);
        end
        rst_n = 1'b0;
        #1;
        expq.delete();
        checkOutput("midreset_out", {14'd0, opl3_reg_wr}, 32'h0);
        checkOutput("midreset_ready", {31'd0, host_ready}, 32'd1);
        checkOutput("midreset_ovf", {31'd0, ovf}, 32'd0);
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = vtimes.size();
        idle(100);
        #1;
        checkOutput("post_reset_pulses", vtimes.size() - n0, 0);
        checkOutput("post_reset_out", {14'd0, opl3_reg_wr}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
